// File: rtl/valu_lane_sequencer.sv
// Issue/collect sequencer for the 8-bit vector ALU: feeds one lane per cycle
// to the VALU and gathers the combinational lane results into a packed vector.
module valu_lane_sequencer #(
  parameter int LANES  = 4,
  parameter int LANE_W = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [2:0]                op,
  input  logic [LANES*LANE_W-1:0]   vecA,
  input  logic [LANES*LANE_W-1:0]   vecB,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [LANES*LANE_W-1:0]   result,
  output logic [LANE_W-1:0]         valu_in1,
  output logic [LANE_W-1:0]         valu_in2,
  output logic [2:0]                valu_op,
  input  logic [LANE_W-1:0]         valu_out
);

  localparam int IDX_W = $clog2(LANES);
  localparam int VEC_W = LANES * LANE_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [VEC_W-1:0] a_q, a_d;
  logic [VEC_W-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [VEC_W-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic             op_legal_s;

  assign op_legal_s = (op == 3'b000) || (op == 3'b001);

  // Next-state: accept in IDLE, capture one lane per edge in ISSUE, single DONE cycle.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op_legal_s) begin
            a_d     = vecA;
            b_d     = vecB;
            op_d    = op;
            idx_d   = {IDX_W{1'b0}};
            state_d = S_ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        result_d[int'(idx_q)*LANE_W +: LANE_W] = valu_out;
        if (idx_q == IDX_W'(LANES - 1)) begin
          idx_d   = {IDX_W{1'b0}};
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any operation and clears the partial result.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= {IDX_W{1'b0}};
      a_q      <= {VEC_W{1'b0}};
      b_q      <= {VEC_W{1'b0}};
      op_q     <= 3'b000;
      result_q <= {VEC_W{1'b0}};
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Operand bus carries the current lane only while issuing, zero otherwise.
  always_comb begin
    if (state_q == S_ISSUE) begin
      valu_in1 = a_q[int'(idx_q)*LANE_W +: LANE_W];
      valu_in2 = b_q[int'(idx_q)*LANE_W +: LANE_W];
    end else begin
      valu_in1 = {LANE_W{1'b0}};
      valu_in2 = {LANE_W{1'b0}};
    end
  end

  assign busy    = (state_q == S_ISSUE);
  assign done    = (state_q == S_DONE);
  assign err     = err_q;
  assign result  = result_q;
  assign valu_op = op_q;

endmodule

// File: tb/tb_valu_lane_sequencer.sv
// Scoreboard bench: stimulus pushes expected completions, a negedge monitor
// pops and compares them whenever done or err is presented.
module tb_valu_lane_sequencer;

  localparam int LANES = 4;
  localparam int W     = LANES * 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] vecA, vecB;
  logic         busy, done, err;
  logic [W-1:0] result;
  logic [7:0]   valu_in1, valu_in2, valu_out;
  logic [2:0]   valu_op;

  valu_lane_sequencer #(.LANES(LANES)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .vecA(vecA), .vecB(vecB), .busy(busy), .done(done), .err(err),
    .result(result), .valu_in1(valu_in1), .valu_in2(valu_in2),
    .valu_op(valu_op), .valu_out(valu_out)
  );

  always #5 clock = ~clock;

  // Stand-in for the combinational VALU.
  logic [15:0] prod_s;
  assign prod_s   = valu_in1 * valu_in2;
  assign valu_out = (valu_op == 3'b000) ? (valu_in1 + valu_in2) : prod_s[7:0];

  typedef struct {
    int           kind;   // 1 = done, 2 = err
    logic [W-1:0] val;
  } exp_t;

  exp_t         sb[$];
  int           n_pass = 0;
  int           n_total = 0;
  int           cyc = 0;
  logic [W-1:0] model_res;
  logic [W-1:0] cur_a, cur_b;
  logic [2:0]   cur_op;
  int           lane_k = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_total++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, expv);
  endtask

  function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] o);
    logic [W-1:0] r;
    int           p;
    for (int i = 0; i < LANES; i++) begin
      if (o == 3'b000) begin
        p = (int'(a[i*8 +: 8]) + int'(b[i*8 +: 8])) % 256;
      end else begin
        p = (int'(a[i*8 +: 8]) * int'(b[i*8 +: 8])) % 256;
      end
      r[i*8 +: 8] = p[7:0];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*8 +: 8] = 8'($urandom_range(0, 255));
    return v;
  endfunction

  // Monitor: protocol checks every cycle, scoreboard pop on done/err.
  always @(negedge clock) begin
    if (!reset) begin
      check("busy_done_exclusive", {62'd0, busy, done} == 64'd3, 64'd0);
      if (busy) begin
        check("lane_in1", valu_in1, cur_a[lane_k*8 +: 8]);
        check("lane_in2", valu_in2, cur_b[lane_k*8 +: 8]);
        check("issue_op", valu_op, cur_op);
        lane_k = lane_k + 1;
      end else begin
        check("idle_in_zero", {valu_in1, valu_in2}, 64'd0);
        lane_k = 0;
      end
      if (done || err) begin
        check("sb_nonempty", sb.size() != 0, 64'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("sb_kind", done ? 64'd1 : 64'd2, e.kind);
          check(done ? "done_result" : "err_result_held", result, e.val);
        end
      end
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] o,
                       input bit inject, output int done_cyc);
    bit legal;
    bit seen;
    int bcnt;
    @(negedge clock);
    start = 1'b1; vecA = a; vecB = b; op = o;
    legal = (o == 3'b000) || (o == 3'b001);
    if (legal) begin
      model_res = ref_op(a, b, o);
      sb.push_back('{kind: 1, val: model_res});
      cur_a = a; cur_b = b; cur_op = o;
    end else begin
      sb.push_back('{kind: 2, val: model_res});
    end
    bcnt = 0; seen = 0; done_cyc = 0;
    for (int i = 0; i < LANES + 6 && !seen; i++) begin
      @(negedge clock);
      start = 1'b0; vecA = rand_vec(); vecB = rand_vec(); op = 3'($urandom_range(0, 7));
      if (busy) begin
        bcnt++;
        if (inject && bcnt == 2) start = 1'b1;
      end
      if (done || err) begin
        seen = 1;
        done_cyc = cyc;
      end
    end
    start = 1'b0;
    check("op_complete", seen, 64'd1);
    check("busy_cycles", bcnt, legal ? LANES : 0);
  endtask

  initial begin
    int c1, c2, dcnt;
    reset = 1'b1; start = 1'b0; op = 3'b000; vecA = '0; vecB = '0;
    model_res = '0; cur_a = '0; cur_b = '0; cur_op = 3'b000;
    repeat (3) @(negedge clock);
    check("rst_busy_done_err", {busy, done, err}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_valu_bus", {valu_in1, valu_in2, 5'd0, valu_op}, 64'd0);
    reset = 1'b0;

    do_op(32'h04030201, 32'h10203040, 3'b000, 1'b0, c1);
    do_op(32'hFF80FF01, 32'h018001FF, 3'b000, 1'b0, c1);
    do_op(32'h10FF0302, 32'h10020504, 3'b001, 1'b0, c1);
    do_op(rand_vec(), rand_vec(), 3'b010, 1'b0, c1);
    do_op(32'h05060708, 32'h11121314, 3'b001, 1'b1, c1);

    // Reset after lane 1 captured: the op is aborted with no done.
    @(negedge clock);
    start = 1'b1; vecA = 32'hA1B2C3D4; vecB = 32'h0F0E0D0C; op = 3'b001;
    cur_a = vecA; cur_b = vecB; cur_op = 3'b001;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    check("abort_busy_done", {busy, done}, 64'd0);
    check("abort_result", result, 64'd0);
    check("abort_valu_bus", {valu_in1, valu_in2}, 64'd0);
    model_res = '0;
    reset = 1'b0;
    dcnt = 0;
    repeat (8) begin
      @(negedge clock);
      if (done) dcnt++;
    end
    check("no_done_after_abort", dcnt, 64'd0);

    do_op(rand_vec(), rand_vec(), 3'b000, 1'b0, c1);
    do_op(rand_vec(), rand_vec(), 3'b001, 1'b0, c2);
    check("b2b_low_cycles", c2 - c1 - 1, LANES + 1);

    for (int n = 0; n < 40; n++) begin
      logic [2:0] o;
      o = ($urandom_range(0, 9) < 2) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
      do_op(rand_vec(), rand_vec(), o, ($urandom_range(0, 3) == 0), c1);
    end

    repeat (3) @(negedge clock);
    check("sb_drained", sb.size(), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/valu_lane_sequencer.md
Name: valu_lane_sequencer

Overview:
- Multicycle issue/collect front end for the 8-bit vector ALU (one lane per cycle).
- Accepts a packed vector operation (two LANES x 8-bit operand vectors plus an opcode) and drives one lane's operands and the opcode onto the VALU input bus each cycle.
- Captures the VALU's combinational 8-bit result into the matching lane of a packed result register.
- Pulses done when all lanes are written. Sits between the vector register file/control FSM and the VALU.

Parameters:
- LANES, 4, number of 8-bit lanes per vector; supported range 2..8.
- LANE_W, 8, lane width; fixed to the VALU width, must not be overridden.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- op  input  3  vector opcode: 000 = ADD, 001 = MUL; all other codes are illegal.
- vecA  input  LANES*8  operand vector A; lane i = bits [8i+7:8i].
- vecB  input  LANES*8  operand vector B; same packing as vecA.
- busy  output  1  high while lanes are being issued (ISSUE state).
- done  output  1  one-cycle pulse; result is valid and complete.
- err  output  1  one-cycle pulse; start was seen with an illegal op.
- result  output  LANES*8  packed lane results; held until the next accepted start or reset.
- valu_in1  output  8  lane operand from A, to VALU in1.
- valu_in2  output  8  lane operand from B, to VALU in2.
- valu_op  output  3  latched opcode, to VALU VALUOp.
- valu_out  input  8  VALU result (combinational, same cycle).

Behaviour:
- Reset (synchronous, active-high, takes priority over everything):
  - state = IDLE, lane index = 0.
  - busy = 0, done = 0, err = 0, result = 0.
  - valu_in1 = 0, valu_in2 = 0, valu_op = 000.
  - Reset mid-ISSUE aborts the operation: no done pulse, partial result cleared.
- States and transitions:
  - IDLE: start=1 and op in {000,001} → latch vecA, vecB, op; idx = 0; go to ISSUE.
  - IDLE: start=1 and op illegal → err = 1 for exactly the next cycle; stay in IDLE; result is untouched.
  - ISSUE: valu_in1/valu_in2 are driven combinationally from latched lane idx; valu_op = latched op.
    - Each rising edge writes valu_out into result lane idx and increments idx.
    - When idx == LANES-1 at the edge, go to DONE.
  - DONE: done = 1 for this single cycle; return to IDLE at the next edge.
- Latency:
  - Start sampled at edge E0; lane i is captured at edge E(i+1).
  - done is high during the cycle following edge E(LANES), so a 4-lane op completes in 4 cycles plus the 1-cycle done pulse.
  - Back-to-back issue is possible: a new start is accepted in the cycle after done.
- Lane isolation:
  - Result lanes not yet written during ISSUE keep their previous values.
  - The result register is not cleared at start; each lane is overwritten when issued.
- Input/output handling:
  - start during ISSUE or DONE is ignored (not queued).
  - vecA/vecB/op changes after acceptance have no effect (latched copies are used).
  - valu_in1/valu_in2 are 0 outside ISSUE, so the VALU sees benign inputs while idle.
- Arithmetic:
  - Lane results are exactly the 8-bit VALU output: ADD wraps mod 256, MUL keeps the low 8 bits of the product.
  - No carries cross lanes; no saturation.
- busy = (state == ISSUE). busy and done are never high in the same cycle.

Test Plan:
- ADD, vecA=0x04030201, vecB=0x10203040, start one cycle → busy high 4 cycles; then done=1 for one cycle with result=0x14233241.
- ADD wrap, vecA=0xFF80FF01, vecB=0x018001FF → result=0x00000000; done pulse once; no carry leaks between lanes.
- MUL, vecA=0x10FF0302, vecB=0x10020504 → result=0x00FE0F08 (lane products 0x08, 0x0F, 0x1FE→0xFE, 0x100→0x00); valu_op=001 throughout ISSUE.
- op=3'b010 with start → err=1 for exactly one cycle; busy stays 0; result keeps its prior value (0x00FE0F08).
- Start a MUL, pulse start again with a new op during ISSUE → ignored; result still matches the first op. Then assert reset after lane 1 is captured → next cycle busy=0, result=0, valu_in1/in2=0, and no done pulse.
- Back-to-back: a second start in the cycle after done → accepted; done pulses separated by exactly LANES+1 cycles.
